// File: rtl/seg7_scan_display.sv
// seg7_scan_display: tear-free 8-digit hex scan of data_i onto active-low an_o/seg_o/dp_o, digit period DIV clk_i cycles, sync active-high rst_i
module seg7_scan_display #(
  parameter int DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        en_i,
  input  logic        blank_lz_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] div_cnt;
  logic [2:0]   idx;
  logic [31:0]  snap;
  logic         load_pend;
  logic         tick;
  logic         blank;
  logic [3:0]   nib;
  logic [6:0]   enc;
  assign tick  = en_i && div_cnt == W'(DIV - 1);
  assign nib   = snap[{idx, 2'b00} +: 4];
  assign blank = blank_lz_i && idx != '0 && (snap >> {idx, 2'b00}) == '0;
  always_comb begin
    enc = 7'h7F;
    case (nib)
      4'h0: enc = 7'h40;
      4'h1: enc = 7'h79;
      4'h2: enc = 7'h24;
      4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;
      4'h5: enc = 7'h12;
      4'h6: enc = 7'h02;
      4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;
      4'h9: enc = 7'h10;
      4'hA: enc = 7'h08;
      4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;
      4'hD: enc = 7'h21;
      4'hE: enc = 7'h06;
      4'hF: enc = 7'h0E;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      idx       <= '0;
      snap      <= '0;
      load_pend <= 1'b1;
      an_o      <= 8'hFF;
      seg_o     <= 7'h7F;
      dp_o      <= 1'b1;
    end else begin
      if (en_i) begin
        div_cnt   <= tick ? '0 : div_cnt + 1'b1;
        idx       <= idx + {2'b00, tick};
        if (load_pend || (tick && idx == 3'd7)) snap <= data_i;
        load_pend <= 1'b0;
      end
      an_o  <= en_i ? ~(8'b1 << idx) : 8'hFF;
      seg_o <= (en_i && !blank) ? enc : 7'h7F;
      dp_o  <= !(en_i && dp_i[idx]);
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed self-checking bench for seg7_scan_display with DIV=4
module tb_seg7_scan_display;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        en_i;
  logic        blank_lz_i;
  logic [7:0]  dp_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  int checks = 0;
  int errors = 0;
  logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_abc [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] seg_caf [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h06, 7'h0E, 7'h08, 7'h46};

  seg7_scan_display #(.DIV(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .en_i(en_i),
    .blank_lz_i(blank_lz_i), .dp_i(dp_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; data_i = 32'h1234ABCD; blank_lz_i = 1'b0; dp_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL reset cyc%0d got an=%h seg=%h dp=%b exp an=ff seg=7f dp=1", i, an_o, seg_o, dp_o);
      end
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (an_o !== 8'hFE) begin
      errors++;
      $display("FAIL first_enabled an got %h exp fe", an_o);
    end
    step();
    checks++;
    if ({an_o, seg_o, dp_o} !== {8'hFE, 7'h21, 1'b1}) begin
      errors++;
      $display("FAIL first_digit got an=%h seg=%h dp=%b exp an=fe seg=21 dp=1", an_o, seg_o, dp_o);
    end
  endtask

  task automatic test_scan();
    for (int d = 0; d < 8; d++)
      for (int c = (d == 0) ? 2 : 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== seg_abc[d]) begin
          errors++;
          $display("FAIL scan d%0d c%0d got an=%h seg=%h exp an=%h seg=%h", d, c, an_o, seg_o, an_tab[d], seg_abc[d]);
        end
      end
  endtask

  task automatic test_snapshot();
    repeat (13) step();
    data_i = 32'h0;
    for (int d = 3; d < 8; d++)
      for (int c = (d == 3) ? 1 : 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== seg_abc[d]) begin
          errors++;
          $display("FAIL tear d%0d c%0d got an=%h seg=%h exp an=%h seg=%h", d, c, an_o, seg_o, an_tab[d], seg_abc[d]);
        end
      end
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== 7'h40) begin
          errors++;
          $display("FAIL zero_scan d%0d c%0d got an=%h seg=%h exp an=%h seg=40", d, c, an_o, seg_o, an_tab[d]);
        end
      end
  endtask

  task automatic test_blank();
    data_i = 32'h000000F0; blank_lz_i = 1'b1;
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== ((d == 0) ? 7'h40 : 7'h7F)) begin
          errors++;
          $display("FAIL blank_zero d%0d c%0d got an=%h seg=%h exp an=%h", d, c, an_o, seg_o, an_tab[d]);
        end
      end
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== ((d == 0) ? 7'h40 : (d == 1) ? 7'h0E : 7'h7F)) begin
          errors++;
          $display("FAIL blank_f0 d%0d c%0d got an=%h seg=%h exp an=%h", d, c, an_o, seg_o, an_tab[d]);
        end
      end
  endtask

  task automatic test_dp_enable();
    dp_i = 8'h04;
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || dp_o !== (d != 2)) begin
          errors++;
          $display("FAIL dp d%0d c%0d got an=%h dp=%b exp an=%h dp=%b", d, c, an_o, dp_o, an_tab[d], d != 2);
        end
      end
    repeat (2) step();
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL disabled cyc%0d got an=%h seg=%h dp=%b exp an=ff seg=7f dp=1", i, an_o, seg_o, dp_o);
      end
    end
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an_o !== ((i < 2) ? 8'hFE : 8'hFD)) begin
        errors++;
        $display("FAIL resume cyc%0d an got %h exp %h", i, an_o, (i < 2) ? 8'hFE : 8'hFD);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    dp_i = 8'h00; blank_lz_i = 1'b0;
    n = 0;
    while (an_o !== 8'hDF && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (an_o !== 8'hDF) begin
      errors++;
      $display("FAIL seek_idx5 an got %h exp df", an_o);
    end
    data_i = 32'hCAFE0000; rst_i = 1'b1;
    step();
    checks++;
    if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b exp an=ff seg=7f dp=1", an_o, seg_o, dp_o);
    end
    rst_i = 1'b0;
    step();
    checks++;
    if (an_o !== 8'hFE) begin
      errors++;
      $display("FAIL post_reset_idx an got %h exp fe", an_o);
    end
    for (int d = 0; d < 8; d++)
      for (int c = (d == 0) ? 1 : 0; c < 4; c++) begin
        step();
        checks++;
        if (an_o !== an_tab[d] || seg_o !== seg_caf[d]) begin
          errors++;
          $display("FAIL reload d%0d c%0d got an=%h seg=%h exp an=%h seg=%h", d, c, an_o, seg_o, an_tab[d], seg_caf[d]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank();
    test_dp_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
